// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the start strobe and operands. The slave returns status and the result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_minuend;
  logic [WIDTH-1:0] i_subtrahend;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_diff;
  logic             o_borrow;

  modport master (
    output i_start, i_minuend, i_subtrahend,
    input  o_busy, o_done, o_diff, o_borrow
  );

  modport slave (
    input  i_start, i_minuend, i_subtrahend,
    output o_busy, o_done, o_diff, o_borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor. It resolves one difference bit per clock, LSB first, through a borrow flop.
// The result and the final borrow only update when an operation completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  serial_subtractor_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_r_sr;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_r_next;

  function automatic logic hs_borrow(input logic a, input logic b);
    return ~a & b;
  endfunction

  // Full-subtract the current LSB pair and pre-form the shifted result word
  always_comb begin
    w_d       = r_a_sr[0] ^ r_b_sr[0] ^ r_br;
    w_br_next = hs_borrow(r_a_sr[0], r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_br);
    w_r_next  = (r_r_sr >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
  end

  // Control FSM, datapath shift registers and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_r_sr   <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.i_start) begin
            r_a_sr  <= bus.i_minuend;
            r_b_sr  <= bus.i_subtrahend;
            r_r_sr  <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_r_sr <= w_r_next;
          r_br   <= w_br_next;
          r_cnt  <= r_cnt + CW'(1);
          r_busy <= 1'b1;
          // Last bit: publish the completed word and borrow together
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_diff   <= w_r_next;
            r_borrow <= w_br_next;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            r_done   <= 1'b0;
            r_state  <= ST_RUN;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy   = r_busy;
  assign bus.o_done   = r_done;
  assign bus.o_diff   = r_diff;
  assign bus.o_borrow = r_borrow;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(1)) bus1 ();

  serial_subtractor #(.WIDTH(8)) u_dut8 (.i_clk(clk), .i_rst(rst), .bus(bus8.slave));
  serial_subtractor #(.WIDTH(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1.slave));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue a start strobe for one edge, leaving the bench in cycle 1 after the start edge
  task automatic start8(input logic [7:0] a, input logic [7:0] b);
    bus8.i_start      = 1'b1;
    bus8.i_minuend    = a;
    bus8.i_subtrahend = b;
    tick();
    bus8.i_start      = 1'b0;
    bus8.i_minuend    = 8'hC3;
    bus8.i_subtrahend = 8'h3C;
  endtask

  // Wait for o_done (bounded); lat is cycles after the start edge, nbusy counts busy cycles seen
  task automatic wait_done8(output int lat, output int nbusy);
    lat   = 1;
    nbusy = (bus8.o_busy === 1'b1) ? 1 : 0;
    while (bus8.o_done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      if (bus8.o_busy === 1'b1) nbusy++;
    end
  endtask

  initial begin
    int lat;
    int nbusy;
    int ndone;
    int last_done;
    logic [1:0] pair;

    vecs[0] = '{a: 8'h05, b: 8'h03, diff: 8'h02, borrow: 1'b0};
    vecs[1] = '{a: 8'h03, b: 8'h05, diff: 8'hFE, borrow: 1'b1};
    vecs[2] = '{a: 8'h00, b: 8'h01, diff: 8'hFF, borrow: 1'b1};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, diff: 8'h00, borrow: 1'b0};
    vecs[4] = '{a: 8'hAA, b: 8'h55, diff: 8'h55, borrow: 1'b0};
    vecs[5] = '{a: 8'h55, b: 8'hAA, diff: 8'hAB, borrow: 1'b1};
    vecs[6] = '{a: 8'hFF, b: 8'h00, diff: 8'hFF, borrow: 1'b0};

    bus8.i_start = 1'b0; bus8.i_minuend = 8'h00; bus8.i_subtrahend = 8'h00;
    bus1.i_start = 1'b0; bus1.i_minuend = 1'b0;  bus1.i_subtrahend = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    chk("reset_busy",   32'(bus8.o_busy),   32'd0);
    chk("reset_done",   32'(bus8.o_done),   32'd0);
    chk("reset_diff",   32'(bus8.o_diff),   32'd0);
    chk("reset_borrow", 32'(bus8.o_borrow), 32'd0);

    // Back-to-back table run: every start lands on the first IDLE cycle after the previous done
    last_done = 0;
    for (int i = 0; i < 7; i++) begin
      start8(vecs[i].a, vecs[i].b);
      wait_done8(lat, nbusy);
      chk($sformatf("latency[%0d]", i), 32'(lat), 32'd9);
      chk($sformatf("busy_cycles[%0d]", i), 32'(nbusy), 32'd9);
      chk($sformatf("diff[%0d]", i), 32'(bus8.o_diff), 32'(vecs[i].diff));
      chk($sformatf("borrow[%0d]", i), 32'(bus8.o_borrow), 32'(vecs[i].borrow));
      if (i > 0) chk($sformatf("interval[%0d]", i), 32'(lat + 1), 32'd10);
      last_done = i;
      tick();
      chk($sformatf("done_pulse_width[%0d]", i), 32'(bus8.o_done), 32'd0);
    end

    // Extra starts during RUN and DONE must be ignored
    tick();
    start8(8'h80, 8'h7F);
    ndone = 0;
    lat = 1;
    while (bus8.o_done !== 1'b1 && lat < 40) begin
      bus8.i_start = (lat == 3);
      bus8.i_minuend = 8'h01; bus8.i_subtrahend = 8'h01;
      tick();
      lat++;
    end
    chk("ignore_latency", 32'(lat), 32'd9);
    bus8.i_start = 1'b1;
    tick();
    bus8.i_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (bus8.o_done === 1'b1) ndone++;
      if (k == 0) chk("ignore_busy_after_done", 32'(bus8.o_busy), 32'd0);
      tick();
    end
    chk("ignore_extra_done", 32'(ndone), 32'd0);
    chk("ignore_diff",   32'(bus8.o_diff),   32'h01);
    chk("ignore_borrow", 32'(bus8.o_borrow), 32'd0);

    // Reset in the 4th RUN cycle aborts the operation and clears the result
    start8(8'h10, 8'h01);
    tick(); tick(); tick();
    chk("abort_busy_before", 32'(bus8.o_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy",   32'(bus8.o_busy),   32'd0);
    chk("abort_diff",   32'(bus8.o_diff),   32'd0);
    chk("abort_borrow", 32'(bus8.o_borrow), 32'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus8.o_done === 1'b1) ndone++;
      tick();
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    start8(8'h10, 8'h01);
    wait_done8(lat, nbusy);
    chk("restart_latency", 32'(lat), 32'd9);
    chk("restart_diff",    32'(bus8.o_diff),   32'h0F);
    chk("restart_borrow",  32'(bus8.o_borrow), 32'd0);
    tick(); tick();

    // Reset and start on the same edge: start is dropped
    rst = 1'b1;
    bus8.i_start = 1'b1; bus8.i_minuend = 8'h09; bus8.i_subtrahend = 8'h02;
    tick();
    rst = 1'b0;
    bus8.i_start = 1'b0;
    chk("rst_start_busy", 32'(bus8.o_busy), 32'd0);
    tick();
    chk("rst_start_busy2", 32'(bus8.o_busy), 32'd0);

    // WIDTH=1: registered half subtractor, done 2 cycles after start
    for (int p = 0; p < 4; p++) begin
      pair = 2'(p);
      bus1.i_start = 1'b1;
      bus1.i_minuend = pair[1];
      bus1.i_subtrahend = pair[0];
      tick();
      bus1.i_start = 1'b0;
      lat = 1;
      while (bus1.o_done !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      chk($sformatf("w1_latency[%0d]", p), 32'(lat), 32'd2);
      chk($sformatf("w1_diff[%0d]", p), 32'(bus1.o_diff), 32'(pair[1] ^ pair[0]));
      chk($sformatf("w1_borrow[%0d]", p), 32'(bus1.o_borrow), 32'(~pair[1] & pair[0]));
      tick(); tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor, the inverse arithmetic companion to the combinational adder cells. It captures a minuend and a subtrahend on a start strobe. It then resolves one difference bit per clock, LSB first, using a half-subtractor stage and a registered borrow. It presents the wrapped difference and the final borrow with a one-cycle done pulse. It is used where area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
i_clk  input  1  system clock; all state updates on rising edge.
i_rst  input  1  reset, synchronous, active-high.
i_start  input  1  start strobe; sampled only in IDLE.
i_minuend  input  WIDTH  operand A; captured on the accepted start.
i_subtrahend  input  WIDTH  operand B; captured on the accepted start.
o_busy  output  1  high whenever state is not IDLE.
o_done  output  1  one-cycle pulse; result is valid.
o_diff  output  WIDTH  (A - B) mod 2^WIDTH; held until the next completion.
o_borrow  output  1  final borrow-out; 1 iff A < B (unsigned); held with o_diff.

Behaviour:
- One clock domain (i_clk). Reset is synchronous and active-high (i_rst); no asynchronous reset anywhere.
- Reset values:
  - state = IDLE; o_busy = 0; o_done = 0; o_diff = 0; o_borrow = 0.
  - Internal shift registers, borrow flop and bit counter are all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If i_start = 1, capture A into shift reg a_sr and B into b_sr.
  - Clear borrow flop br and bit counter cnt, then go to RUN.
  - If i_start = 0, remain in IDLE.
- RUN, each cycle:
  - d = a_sr[0] ^ b_sr[0] ^ br.
  - br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br).
  - Shift d into the result shift register r_sr at the MSB, shifting right.
  - Shift a_sr and b_sr right by one; cnt increments.
  - When cnt reaches WIDTH-1 in this cycle (the last bit), the next state is DONE.
  - At that same edge, o_diff loads the completed r_sr value (including this last bit) and o_borrow loads br_next.
- DONE:
  - o_done = 1 for exactly this one cycle; next state is IDLE unconditionally.
- Latency:
  - Start sampled at edge E0; RUN spans edges E1..E_WIDTH.
  - o_done is high in the cycle after E_WIDTH, i.e. WIDTH+1 cycles after the start edge.
  - Back-to-back throughput is one operation per WIDTH+2 cycles.
- i_start is ignored in RUN and in DONE; there is no queuing.
- i_minuend and i_subtrahend are don't-care except at the accepted start edge.
- o_diff and o_borrow change only on entry to DONE. Partial results are never visible, and values hold through IDLE indefinitely.
- Counter width is clog2(WIDTH+1); it never wraps within an operation.
- WIDTH = 1 degenerates to a registered half subtractor (diff = A ^ B, borrow = ~A & B) with latency 2.
- Reset asserted mid-operation (RUN or DONE):
  - All state returns to reset values at that edge.
  - No o_done pulse follows; o_diff and o_borrow read 0.
- Reset and i_start asserted on the same edge: reset wins and the start is dropped.

Test Plan:
1. WIDTH=8, A=0x05, B=0x03, start -> o_done exactly 9 cycles after the start edge; o_diff=0x02, o_borrow=0; o_busy high for 9 cycles.
2. WIDTH=8, A=0x03, B=0x05 -> o_diff=0xFE, o_borrow=1. Then A=0x00, B=0x01 -> o_diff=0xFF, o_borrow=1. Then A=0xFF, B=0xFF -> o_diff=0x00, o_borrow=0.
3. WIDTH=8, A=0x80, B=0x7F, start; pulse i_start again with A=0x01, B=0x01 during RUN and during DONE -> single o_done, o_diff=0x01, o_borrow=0; the extra starts have no effect.
4. WIDTH=8, start A=0x10, B=0x01; assert i_rst for 1 cycle at the 4th RUN cycle -> o_busy=0 next cycle, no o_done, o_diff=0x00. A fresh start with A=0x10, B=0x01 -> o_diff=0x0F.
5. WIDTH=8, start on the first IDLE cycle after each o_done for 4 operations -> o_done every 10 cycles. Results: 0xAA-0x55 gives 0x55/0; 0x55-0xAA gives 0xAB/1; 0x00-0x00 gives 0x00/0; 0xFF-0x00 gives 0xFF/0.
6. WIDTH=1, all four input pairs (0,0), (0,1), (1,0), (1,1) -> borrow/diff = 0/0, 1/1, 0/1, 0/0; o_done 2 cycles after each start.
